norm2_udiv_47ns_6ns_41_seq: RTL and testbench

NORM2_UDIV_47NS_6NS_41_SEQ -- requirements
Module: norm2_udiv_47ns_6ns_41_seq

---
 rtl/norm2_div_pkg.sv | 20 ++
 rtl/norm2_udiv_47ns_6ns_41_seq_if.sv | 27 ++
 rtl/norm2_udiv_step.sv | 19 +
 rtl/norm2_udiv_47ns_6ns_41_seq.sv | 133 +++++++++++++
 tb/tb_norm2_udiv_47ns_6ns_41_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/norm2_div_pkg.sv
// Shared widths, iteration count and FSM encoding for the sequential unsigned divider.
package norm2_div_pkg;

    localparam int DIN0_W = 47;
    localparam int DIN1_W = 6;
    localparam int DOUT_W = 41;
    localparam int ITERS  = DIN0_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Counter must be able to hold the full iteration count.
    function automatic int cnt_width(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/norm2_udiv_47ns_6ns_41_seq_if.sv
// Request/result bundle of the sequential divider; clock and reset stay outside.
interface norm2_udiv_47ns_6ns_41_seq_if #(
    parameter int din0_WIDTH = norm2_div_pkg::DIN0_W,
    parameter int din1_WIDTH = norm2_div_pkg::DIN1_W,
    parameter int dout_WIDTH = norm2_div_pkg::DOUT_W
);
    logic                  ce;
    logic                  start;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  ready;
    logic                  done;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, dout, rem, ovf, dbz
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, dout, rem, ovf, dbz
    );
endinterface

// File: rtl/norm2_udiv_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, keep or restore.
module norm2_udiv_step #(
    parameter int DIV_W = norm2_div_pkg::DIN1_W
) (
    input  logic [DIV_W:0]   rem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [DIV_W:0]   rem_o,
    output logic             q_o
);
    logic [DIV_W+1:0] shifted;
    logic [DIV_W:0]   diff;

    assign shifted = {rem_i, bit_i};
    // The kept remainder is always below the divisor, so the low bits of the difference suffice.
    assign diff    = shifted[DIV_W:0] - {1'b0, div_i};
    assign q_o     = (shifted >= {2'b00, div_i});
    assign rem_o   = q_o ? diff : shifted[DIV_W:0];
endmodule

// File: rtl/norm2_udiv_47ns_6ns_41_seq.sv
// Sequential restoring divider: one quotient bit per enabled clock, MSB first.
// Operands are captured on an accepted start; results hold until the next done.
module norm2_udiv_47ns_6ns_41_seq
    import norm2_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    norm2_udiv_47ns_6ns_41_seq_if.slave        bus
);
    localparam int                CNT_W    = cnt_width(din0_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(din0_WIDTH - 1);
    localparam logic [1:0]        ST_IDLE  = S_IDLE;
    localparam logic [1:0]        ST_BUSY  = S_BUSY;
    localparam logic [1:0]        ST_DONE  = S_DONE;

    logic                  unused_id;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [din0_WIDTH-1:0] work_q, work_d;
    logic [din1_WIDTH:0]   part_q, part_d;
    logic [din1_WIDTH-1:0] div_q, div_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [din1_WIDTH-1:0] rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;
    logic [din1_WIDTH:0]   step_rem;
    logic                  step_q;
    logic [din0_WIDTH-1:0] quot_next;
    logic                  quot_hi;
    logic                  div_zero;

    assign unused_id = ^ID;

    norm2_udiv_step #(.DIV_W(din1_WIDTH)) u_step (
        .rem_i (part_q),
        .bit_i (work_q[din0_WIDTH-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // The dividend register doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign quot_next = {work_q[din0_WIDTH-2:0], step_q};
    assign div_zero  = (div_q == '0);

    generate
        if (din0_WIDTH > dout_WIDTH) begin : g_ovf
            assign quot_hi = |quot_next[din0_WIDTH-1:dout_WIDTH];
        end else begin : g_no_ovf
            assign quot_hi = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        part_d  = part_q;
        div_d   = div_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        if (bus.ce) begin
            case (state_q)
                ST_BUSY: begin
                    work_d = quot_next;
                    part_d = step_rem;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        dbz_d   = div_zero;
                        ovf_d   = ~div_zero & quot_hi;
                        dout_d  = div_zero ? '1 : quot_next[dout_WIDTH-1:0];
                        // With a zero divisor every trial succeeds, so the partial remainder ends
                        // up holding the low dividend bits, which is exactly the required rem.
                        rem_d   = step_rem[din1_WIDTH-1:0];
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        work_d  = bus.din0;
                        part_d  = '0;
                        div_d   = bus.din1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            part_q  <= '0;
            div_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            part_q  <= part_d;
            div_q   <= div_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.dout  = dout_q;
    assign bus.rem   = rem_q;
    assign bus.ovf   = ovf_q;
    assign bus.dbz   = dbz_q;
endmodule

// File: tb/tb_norm2_udiv_47ns_6ns_41_seq.sv
// Randomised and directed checks of the sequential divider against an arithmetic model.
module tb_norm2_udiv_47ns_6ns_41_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [40:0] prev_dout;
    logic [5:0]  prev_rem;
    logic        prev_ovf;
    logic        prev_dbz;

    norm2_udiv_47ns_6ns_41_seq_if bus ();

    norm2_udiv_47ns_6ns_41_seq #(
        .ID         (1),
        .din0_WIDTH (47),
        .din1_WIDTH (6),
        .dout_WIDTH (41)
    ) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [46:0] a, input logic [5:0] b,
                                  output logic [40:0] q, output logic [5:0] r,
                                  output logic ov, output logic dz);
        longint unsigned qa;
        if (b == 6'd0) begin
            q  = '1;
            r  = a[5:0];
            ov = 1'b0;
            dz = 1'b1;
        end else begin
            qa = 64'(a) / 64'(b);
            q  = qa[40:0];
            r  = 6'(64'(a) % 64'(b));
            ov = (qa >> 41) != 0;
            dz = 1'b0;
        end
    endfunction

    // Starts one operation and returns in the cycle where done is first seen.
    task automatic run_op(input string tag, input logic [46:0] a, input logic [5:0] b,
                          input int stall_at, input int stall_len, input int poke1, input int poke2);
        logic [40:0] q;
        logic [5:0]  r;
        logic        ov, dz;
        int          lat;
        model(a, b, q, r, ov, dz);
        bus.ce    = 1'b1;
        bus.din0  = a;
        bus.din1  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.din0  = 47'({$urandom, $urandom});
        bus.din1  = 6'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 300) begin
            bus.ce    = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
            bus.start = (lat == poke1) || (lat == poke2);
            if (lat == 3) begin
                chk({tag, "_busy_ready"}, 64'(bus.ready), 64'(0));
                chk({tag, "_hold_dout"}, 64'(bus.dout), 64'(prev_dout));
                chk({tag, "_hold_rem"}, 64'(bus.rem), 64'(prev_rem));
                chk({tag, "_hold_flags"}, 64'({bus.ovf, bus.dbz}), 64'({prev_ovf, prev_dbz}));
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        bus.ce    = 1'b1;
        chk({tag, "_latency"}, 64'(lat), 64'(48 + stall_len));
        chk({tag, "_dout"}, 64'(bus.dout), 64'(q));
        chk({tag, "_rem"}, 64'(bus.rem), 64'(r));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ov));
        chk({tag, "_dbz"}, 64'(bus.dbz), 64'(dz));
        $display("op %s a=%0d b=%0d dout=%0h rem=%0d ovf=%0b dbz=%0b lat=%0d",
                 tag, a, b, bus.dout, bus.rem, bus.ovf, bus.dbz, lat);
        prev_dout = q;
        prev_rem  = r;
        prev_ovf  = ov;
        prev_dbz  = dz;
    endtask

    task automatic finish_op();
        tick();
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        chk("ready_after_done", 64'(bus.ready), 64'(1));
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk(tag, 64'(seen), 64'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready), 64'(1));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_dout"}, 64'(bus.dout), 64'(0));
        chk({tag, "_rem"}, 64'(bus.rem), 64'(0));
        chk({tag, "_flags"}, 64'({bus.ovf, bus.dbz}), 64'(0));
    endtask

    initial begin
        logic [46:0] ra;
        logic [5:0]  rb;
        bus.ce    = 1'b1;
        bus.start = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        prev_dout = '0;
        prev_rem  = '0;
        prev_ovf  = 1'b0;
        prev_dbz  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_zero_outputs("reset");

        run_op("div100_7", 47'd100, 6'd7, 0, 0, -1, -1);
        finish_op();
        run_op("max_q", 47'(((64'd1 << 41) - 64'd1) * 64'd63), 6'd63, 0, 0, -1, -1);
        finish_op();
        run_op("ovf", 47'(64'd1 << 46), 6'd1, 0, 0, -1, -1);
        finish_op();
        run_op("dbz", 47'h2A, 6'd0, 0, 0, -1, -1);
        finish_op();

        // Abort an operation with reset in its 20th cycle.
        bus.din0  = 47'd100;
        bus.din1  = 6'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("mid_reset");
        prev_dout = '0;
        prev_rem  = '0;
        prev_ovf  = 1'b0;
        prev_dbz  = 1'b0;
        no_done_for("reset_abort_no_done", 60);
        run_op("after_reset", 47'd100, 6'd7, 0, 0, -1, -1);
        finish_op();

        run_op("busy_start", 47'd1000, 6'd13, 0, 0, 5, 30);
        finish_op();
        no_done_for("busy_start_not_queued", 60);

        run_op("ce_stall", 47'd100, 6'd7, 10, 10, -1, -1);
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_held_ce_low", 64'(bus.done), 64'(1));
        end
        bus.ce = 1'b1;
        tick();
        chk("done_drop_ce_high", 64'(bus.done), 64'(0));

        run_op("b2b_first", 47'd500, 6'd9, 0, 0, -1, -1);
        run_op("b2b_second", 47'd12345, 6'd11, 0, 0, -1, -1);
        finish_op();

        for (int i = 0; i < 16; i++) begin
            ra = 47'({$urandom, $urandom}) >> $urandom_range(0, 46);
            rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            run_op("rand", ra, rb, 0, 0, -1, -1);
            if ($urandom_range(0, 1) == 1) finish_op();
        end
        finish_op();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
